// File: rtl/matrix_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_feeder_pkg
// Brief    : Shared types and helpers for the systolic-array operand feeder:
//            FSM state encoding, beat-count function, address-range check.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_feeder_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Data beats plus the zero beats needed to drain the array's skew registers.
    function automatic int total_beats(input int m, input int n, input int l);
        return n + m + l - 2;
    endfunction

    // True when a row-major element index falls inside a buffer of 'limit' entries.
    function automatic logic addr_in_range(input int addr, input int limit);
        return (addr < limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_feeder_if
// Brief    : Host write / command port and array streaming port of the
//            matrix feeder. 'master' is the host+array side, 'slave' the feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_feeder_if #(
    parameter int WIDTH_left = 8,
    parameter int WIDTH_up   = 8,
    parameter int WR_W       = 16,
    parameter int Mritx_M    = 3,
    parameter int Mritx_L    = 3,
    parameter int ADDR_W     = 8
) ();

    logic                        wr_en;
    logic                        wr_sel;
    logic [ADDR_W-1:0]           wr_addr;
    logic [WR_W-1:0]             wr_data;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        arr_ready;
    logic                        arr_valid;
    logic [Mritx_M*WIDTH_left-1:0] arr_left;
    logic [Mritx_L*WIDTH_up-1:0]   arr_up;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, arr_ready,
        input  busy, done, arr_valid, arr_left, arr_up
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, arr_ready,
        output busy, done, arr_valid, arr_left, arr_up
    );

endinterface
`default_nettype wire

// File: rtl/matrix_feeder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : feeder_buffer
// Brief    : A (MxN) and B (NxL) operand register file. Decoded host write
//            port; combinational read of column k of A and row k of B, with
//            all-zero lanes for k >= N (flush beats).
// Revision : 1.0 - initial release
// ============================================================================
module feeder_buffer
    import matrix_feeder_pkg::*;
#(
    parameter int WIDTH_left = 8,
    parameter int WIDTH_up   = 8,
    parameter int WR_W       = 16,
    parameter int Mritx_M    = 3,
    parameter int Mritx_N    = 3,
    parameter int Mritx_L    = 3,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 10
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_wr_en,
    input  wire logic                          i_wr_sel,
    input  wire logic [ADDR_W-1:0]             i_wr_addr,
    input  wire logic [WR_W-1:0]               i_wr_data,
    input  wire logic [CNT_W-1:0]              i_rd_k,
    output logic      [Mritx_M*WIDTH_left-1:0] o_col_a,
    output logic      [Mritx_L*WIDTH_up-1:0]   o_row_b
);

    localparam int c_A_SIZE = Mritx_M * Mritx_N;
    localparam int c_B_SIZE = Mritx_N * Mritx_L;

    logic [WIDTH_left-1:0] r_a [c_A_SIZE];
    logic [WIDTH_up-1:0]   r_b [c_B_SIZE];

    // Upper host data bits carry no information for these element widths.
    logic w_unused_wr_data;
    assign w_unused_wr_data = ^i_wr_data;

    // Element-wise decoded write; addresses beyond the buffer match nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int e = 0; e < c_A_SIZE; e++) r_a[e] <= '0;
            for (int e = 0; e < c_B_SIZE; e++) r_b[e] <= '0;
        end else if (i_wr_en) begin
            for (int e = 0; e < c_A_SIZE; e++)
                if (!i_wr_sel && i_wr_addr == ADDR_W'(e))
                    r_a[e] <= i_wr_data[WIDTH_left-1:0];
            for (int e = 0; e < c_B_SIZE; e++)
                if (i_wr_sel && i_wr_addr == ADDR_W'(e))
                    r_b[e] <= i_wr_data[WIDTH_up-1:0];
        end
    end

    // Column k of A onto left lanes, row k of B onto up lanes; zero when k >= N.
    always_comb begin
        o_col_a = '0;
        o_row_b = '0;
        for (int k = 0; k < Mritx_N; k++) begin
            if (i_rd_k == CNT_W'(k)) begin
                for (int i = 0; i < Mritx_M; i++)
                    o_col_a[i*WIDTH_left +: WIDTH_left] = r_a[i*Mritx_N + k];
                for (int j = 0; j < Mritx_L; j++)
                    o_row_b[j*WIDTH_up +: WIDTH_up] = r_b[k*Mritx_L + j];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module   : matrix_feeder
// Brief    : Buffers host-written operand matrices and streams them into the
//            systolic array: N data beats followed by M+L-2 zero flush beats.
//            All outputs registered; each beat is prepared one cycle early.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_feeder
    import matrix_feeder_pkg::*;
#(
    parameter int WIDTH_left = 8,
    parameter int WIDTH_up   = 8,
    parameter int WR_W       = 16,
    parameter int Mritx_M    = 3,
    parameter int Mritx_N    = 3,
    parameter int Mritx_L    = 3,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 10
) (
    input  wire logic      clk,
    input  wire logic      rst,
    matrix_feeder_if.slave bus
);

    localparam int c_TOTAL  = total_beats(Mritx_M, Mritx_N, Mritx_L);
    localparam int c_A_SIZE = Mritx_M * Mritx_N;
    localparam int c_B_SIZE = Mritx_N * Mritx_L;

    state_t                        r_state, w_state_nxt;
    logic [CNT_W-1:0]              r_cnt, w_cnt_nxt;
    logic                          r_busy, w_busy_nxt;
    logic                          r_done, w_done_nxt;
    logic                          r_valid, w_valid_nxt;
    logic                          w_load;
    logic [CNT_W-1:0]              w_rd_k;
    logic                          w_wr_ok;
    logic [Mritx_M*WIDTH_left-1:0] r_left, w_col_a;
    logic [Mritx_L*WIDTH_up-1:0]   r_up, w_row_b;

    // Host writes land only while idle and inside the selected matrix.
    assign w_wr_ok = bus.wr_en && (r_state == ST_IDLE) &&
                     addr_in_range(int'(bus.wr_addr), bus.wr_sel ? c_B_SIZE : c_A_SIZE);

    feeder_buffer #(
        .WIDTH_left (WIDTH_left),
        .WIDTH_up   (WIDTH_up),
        .WR_W       (WR_W),
        .Mritx_M    (Mritx_M),
        .Mritx_N    (Mritx_N),
        .Mritx_L    (Mritx_L),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_ok),
        .i_wr_sel  (bus.wr_sel),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_k    (w_rd_k),
        .o_col_a   (w_col_a),
        .o_row_b   (w_row_b)
    );

    // Next-state and next-output decisions; r_cnt is the beat currently on the bus.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_load      = 1'b0;
        w_rd_k      = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_WAIT_RDY;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                if (bus.arr_ready) begin
                    w_state_nxt = ST_STREAM;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_load      = 1'b1;
                end
            end
            ST_STREAM: begin
                if (r_cnt == CNT_W'(c_TOTAL - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_valid_nxt = 1'b1;
                    w_load      = 1'b1;
                    w_rd_k      = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, beat counter and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Lane registers: buffer read for the upcoming beat, zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_left <= '0;
            r_up   <= '0;
        end else begin
            r_left <= w_load ? w_col_a : '0;
            r_up   <= w_load ? w_row_b : '0;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.arr_valid = r_valid;
    assign bus.arr_left  = r_left;
    assign bus.arr_up    = r_up;

endmodule
`default_nettype wire

// File: tb/tb_matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_feeder
// Brief    : Self-checking bench for matrix_feeder. Directed scenarios plus
//            randomized host writes / ready delays, checked against a matrix
//            model that derives each beat directly from A and B.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_feeder;

    localparam int WL = 8;
    localparam int WU = 8;
    localparam int WR_W = 16;
    localparam int M = 3;
    localparam int N = 3;
    localparam int L = 3;
    localparam int ADDR_W = 8;
    localparam int CNT_W = 10;
    localparam int TOTAL = N + M + L - 2;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference operand matrices, row-major.
    int ma [M*N];
    int mb [N*L];

    matrix_feeder_if #(
        .WIDTH_left(WL), .WIDTH_up(WU), .WR_W(WR_W),
        .Mritx_M(M), .Mritx_L(L), .ADDR_W(ADDR_W)
    ) bus ();

    matrix_feeder #(
        .WIDTH_left(WL), .WIDTH_up(WU), .WR_W(WR_W),
        .Mritx_M(M), .Mritx_N(N), .Mritx_L(L),
        .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [M*WL-1:0] exp_left(input int k);
        logic [M*WL-1:0] v;
        v = '0;
        for (int i = 0; i < M; i++)
            v[i*WL +: WL] = (k < N) ? WL'(ma[i*N + k]) : '0;
        return v;
    endfunction

    function automatic logic [L*WU-1:0] exp_up(input int k);
        logic [L*WU-1:0] v;
        v = '0;
        for (int j = 0; j < L; j++)
            v[j*WU +: WU] = (k < N) ? WU'(mb[k*L + j]) : '0;
        return v;
    endfunction

    // Model of an idle-time host write: only in-range elements change.
    task automatic model_write(input int sel, input int addr, input int data);
        if (sel == 0 && addr < M*N) ma[addr] = data % 256;
        if (sel == 1 && addr < N*L) mb[addr] = data % 256;
    endtask

    task automatic model_clear();
        for (int e = 0; e < M*N; e++) ma[e] = 0;
        for (int e = 0; e < N*L; e++) mb[e] = 0;
    endtask

    task automatic host_write(input int sel, input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel[0];
        bus.wr_addr = ADDR_W'(addr);
        bus.wr_data = WR_W'(data);
        @(negedge clk);
        bus.wr_en = 1'b0;
        model_write(sel, addr, data);
    endtask

    // One full operation; optional same-cycle A[0] write and a write while busy.
    task automatic run_op(input int ready_delay, input bit same_wr, input int same_val,
                          input bit busy_wr);
        int waited;
        bus.start = 1'b1;
        if (same_wr) begin
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = '0;
            bus.wr_data = WR_W'(same_val);
            model_write(0, 0, same_val);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check_eq("busy_after_start", 64'(bus.busy), 64'd1);
        bus.arr_ready = 1'b0;
        for (int d = 0; d < ready_delay; d++) begin
            check_eq("valid_low_wait_rdy", 64'(bus.arr_valid), 64'd0);
            check_eq("busy_wait_rdy", 64'(bus.busy), 64'd1);
            @(negedge clk);
        end
        bus.arr_ready = 1'b1;
        @(negedge clk);
        waited = 0;
        while (!bus.arr_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        bus.arr_ready = 1'b0;
        if (!bus.arr_valid) begin
            check_eq("first_beat_timeout", 64'd0, 64'd1);
            return;
        end
        check_eq("first_beat_latency", 64'(waited), 64'd0);
        for (int k = 0; k < TOTAL; k++) begin
            check_eq($sformatf("valid_beat%0d", k), 64'(bus.arr_valid), 64'd1);
            check_eq($sformatf("left_beat%0d", k), 64'(bus.arr_left), 64'(exp_left(k)));
            check_eq($sformatf("up_beat%0d", k), 64'(bus.arr_up), 64'(exp_up(k)));
            check_eq($sformatf("done_low_beat%0d", k), 64'(bus.done), 64'd0);
            if (busy_wr && k == 1) begin
                bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = '0;
                bus.wr_data = WR_W'(99);
            end else begin
                bus.wr_en = 1'b0;
            end
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        check_eq("valid_low_after_last", 64'(bus.arr_valid), 64'd0);
        check_eq("done_pulse", 64'(bus.done), 64'd1);
        check_eq("busy_low_at_done", 64'(bus.busy), 64'd0);
        check_eq("lanes_zero_at_done", 64'({bus.arr_left, bus.arr_up}), 64'd0);
        @(negedge clk);
        check_eq("done_single_cycle", 64'(bus.done), 64'd0);
    endtask

    // Reset asserted while beat 2 is on the bus aborts with no done pulse.
    task automatic reset_mid_op();
        int beats;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.arr_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 10 && beats < 3; c++) begin
            @(negedge clk);
            bus.arr_ready = 1'b0;
            if (bus.arr_valid) beats++;
        end
        check_eq("reached_beat2", 64'(beats), 64'd3);
        rst = 1'b0;
        @(negedge clk);
        model_clear();
        check_eq("rst_mid_valid", 64'(bus.arr_valid), 64'd0);
        check_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_mid_done", 64'(bus.done), 64'd0);
        check_eq("rst_mid_lanes", 64'({bus.arr_left, bus.arr_up}), 64'd0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("no_done_after_abort", 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.arr_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_valid", 64'(bus.arr_valid), 64'd0);
        check_eq("rst_lanes", 64'({bus.arr_left, bus.arr_up}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_valid", 64'(bus.arr_valid), 64'd0);

        // A = 1..9 row-major, B = identity; ready withheld for three cycles.
        for (int e = 0; e < 9; e++) host_write(0, e, e + 1);
        for (int k = 0; k < N; k++)
            for (int j = 0; j < L; j++) host_write(1, k*L + j, (k == j) ? 1 : 0);
        check_eq("model_beat0_left", 64'(exp_left(0)), 64'h070401);
        run_op(3, 1'b0, 0, 1'b1);

        // The write of 99 during busy must not show up here.
        run_op(0, 1'b0, 0, 1'b0);

        // Out-of-range A write and B write are dropped.
        host_write(0, 9, 8'h55);
        host_write(1, 12, 8'h66);
        run_op(1, 1'b0, 0, 1'b0);

        // Write landing in the same cycle as start.
        run_op(0, 1'b1, 5, 1'b0);

        reset_mid_op();
        run_op(0, 1'b0, 0, 1'b0);

        // Randomized host traffic (upper data bits and stray addresses included).
        for (int r = 0; r < 6; r++) begin
            int nwr;
            nwr = int'($urandom_range(1, 6));
            for (int w = 0; w < nwr; w++)
                host_write(int'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
                           int'($urandom_range(0, 65535)));
            run_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/matrix_feeder.md
# matrix_feeder

Upstream loader for the systolic matrix multiplier array. Holds operand matrices A (M×N) and B (N×L) in local register buffers written by a host, then, on a start command and once the array signals ready, streams A one column per beat on the left bus and B one row per beat on the up bus. After the N data beats it streams zero flush beats so the array's internal skew registers drain. It sits directly between the host/memory interface and the array's `valid/left/up/ready` port.

## Interface
- `WIDTH_left`, 8, element width of A and of each left-bus lane
- `WIDTH_up`, 8, element width of B and of each up-bus lane
- `WR_W`, 16, host write-data width; must be ≥ max(`WIDTH_left`, `WIDTH_up`)
- `Mritx_M`, 3, rows of A = left lanes
- `Mritx_N`, 3, inner dimension = data beats
- `Mritx_L`, 3, columns of B = up lanes
- `ADDR_W`, 8, host address width; must cover max(M·N, N·L)
- `CNT_W`, 10, beat-counter width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `wr_en`  in  1  host write strobe
- `wr_sel`  in  1  0 = write A, 1 = write B
- `wr_addr`  in  ADDR_W  row-major element index: A[i][k] at i·N+k; B[k][j] at k·L+j
- `wr_data`  in  WR_W  element value; low bits used, upper bits ignored
- `start`  in  1  single-cycle request to stream the buffered matrices
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle pulse after the last beat
- `arr_ready`  in  1  array can accept a new operation
- `arr_valid`  out  1  beat valid to array
- `arr_left`  out  M·WIDTH_left  lane i = A[i][k] at beat k
- `arr_up`  out  L·WIDTH_up  lane j = B[k][j] at beat k

## Operation
- `TOTAL = N + M + L − 2` beats per operation: beats 0..N−1 carry data, beats N..TOTAL−1 carry zeros on all lanes.
- FSM states: IDLE, WAIT_RDY, STREAM, DONE.
- IDLE: `start`=1 → WAIT_RDY, `busy`←1. `start` ignored in all other states.
- WAIT_RDY: `arr_ready`=1 → STREAM, beat counter←0; otherwise hold, `arr_valid`=0.
- STREAM: `arr_valid`=1 every cycle; counter increments; `arr_ready` is not sampled (the array drops it after accepting). Counter = TOTAL−1 → DONE.
- DONE: `done`=1, `busy`←0, `arr_valid`=0, lanes zero; → IDLE next cycle.
- Writes are accepted in IDLE only. Writes while `busy`=1 or with address ≥ M·N (A) or ≥ N·L (B) are dropped; buffers are unchanged.
- `wr_en` and `start` in the same IDLE cycle: the write lands and is visible to the operation.
- Buffers are not cleared by an operation; rewriting only changed elements is legal.

## Timing
- Reset: `busy`=0, `done`=0, `arr_valid`=0, `arr_left`=0, `arr_up`=0, buffers all zero, FSM IDLE.
- All outputs are registered. `start` at edge t → `busy`=1 at t+1. With `arr_ready`=1 at t+1 → first beat (`arr_valid`=1, beat 0) at t+2.
- Beat k is held for exactly one cycle; `arr_valid` is high for exactly TOTAL consecutive cycles.
- `done` is high the cycle after the last beat; next `start` is accepted the cycle after `done`.
- Reset asserted mid-operation: the next edge forces reset values, `arr_valid`=0, and the operation is aborted with no `done` pulse.
- Lane packing: lane i occupies bits [(i+1)·W−1 : i·W].

## Structure
- Shared package: FSM state encoding, `TOTAL` beat-count function, address-range helper.
- One sub-module, `feeder_buffer`: the A/B register file with host write port and combinational column-k (A) / row-k (B) read, with zero returned for k ≥ N. `matrix_feeder` holds the FSM, counter, and output registers.

## Test plan
- Reset, then idle: all outputs 0; `start` with `arr_ready`=0 → `busy`=1, `arr_valid` stays 0 until `arr_ready`=1.
- M=N=L=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, start with ready → beats 0..2: left={7,4,1} msb→lsb per column (beat0 lanes 1,4,7), up=row k of I; beats 3..6 all zero; `arr_valid` high for 7 cycles; `done` on cycle 8.
- Write during `busy` (A[0]=99) → dropped; the next operation streams the original A[0]=1.
- Out-of-range write (wr_addr=9, M·N=9) → no buffer change.
- `start`+`wr_en` (A[0]=5) in the same cycle → beat 0 lane 0 = 5.
- Reset asserted at beat 2 → `arr_valid`=0 the next cycle, no `done`; new start streams a full 7-beat operation with zero buffers.
